// File: rtl/rename_pkg.sv
// Shared rename types and sizing: architectural/physical register counts and index typedefs.
package rename_pkg;
    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 64;
    localparam int AW        = $clog2(ARCH_REGS);
    localparam int PW        = $clog2(PHYS_REGS);

    typedef logic [AW-1:0] arch_reg_t;
    typedef logic [PW-1:0] phys_reg_t;
endpackage

// File: rtl/rename_free_list.sv
// Circular FIFO of free physical registers, preloaded with the registers not mapped at reset.
module rename_free_list
    import rename_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    input  logic      pop,
    input  logic      push,
    input  phys_reg_t push_reg,
    output phys_reg_t head_reg,
    output logic      empty
);
    localparam int CW = PW + 1;

    phys_reg_t       mem [PHYS_REGS];
    phys_reg_t       head;
    phys_reg_t       tail;
    logic [CW-1:0]   count;
    logic            pop_ok;
    logic            push_ok;

    assign empty    = (count == '0);
    assign head_reg = mem[head];
    assign pop_ok   = pop && !empty;
    // Register 0 is the hardwired zero and never enters the pool; a full push is dropped.
    assign push_ok  = push && (push_reg != '0) && (count != CW'(PHYS_REGS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PHYS_REGS; i++) begin
                mem[i] <= (i < ARCH_REGS) ? phys_reg_t'(i + ARCH_REGS) : '0;
            end
            head  <= '0;
            tail  <= phys_reg_t'(ARCH_REGS);
            count <= CW'(ARCH_REGS);
        end else begin
            if (pop_ok) begin
                head <= head + phys_reg_t'(1);
            end
            if (push_ok) begin
                mem[tail] <= push_reg;
                tail      <= tail + phys_reg_t'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/register_rename.sv
// Rename stage: RAT lookup of sources/destination and physical destination allocation from the free list.
module register_rename
    import rename_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    input  arch_reg_t rd,
    input  arch_reg_t rs1,
    input  arch_reg_t rs2,
    input  logic      issue_valid,
    input  logic      retire_valid,
    input  phys_reg_t retire_phys_reg,
    output phys_reg_t phys_rd,
    output phys_reg_t phys_rs1,
    output phys_reg_t phys_rs2,
    output phys_reg_t old_phys_rd,
    output logic      free_list_empty
);
    phys_reg_t rat [ARCH_REGS];
    phys_reg_t head_reg;
    logic      alloc;

    assign alloc = issue_valid && (rd != '0) && !free_list_empty;

    rename_free_list u_free_list (
        .clk      (clk),
        .reset_n  (reset_n),
        .pop      (alloc),
        .push     (retire_valid),
        .push_reg (retire_phys_reg),
        .head_reg (head_reg),
        .empty    (free_list_empty)
    );

    // Reads see the pre-edge RAT, so a source equal to rd returns the old mapping.
    assign phys_rs1    = (rs1 == '0) ? '0 : rat[rs1];
    assign phys_rs2    = (rs2 == '0) ? '0 : rat[rs2];
    assign old_phys_rd = (rd  == '0) ? '0 : rat[rd];
    assign phys_rd     = ((rd == '0) || free_list_empty) ? '0 : head_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat[i] <= phys_reg_t'(i);
            end
        end else if (alloc) begin
            rat[rd] <= head_reg;
        end
    end
endmodule

// File: tb/tb_register_rename.sv
// Scoreboard bench for register_rename against a queue-based rename model.
module tb_register_rename;
    import rename_pkg::*;

    logic      clk = 1'b0;
    logic      reset_n;
    arch_reg_t rd, rs1, rs2;
    logic      issue_valid, retire_valid;
    phys_reg_t retire_phys_reg;
    phys_reg_t phys_rd, phys_rs1, phys_rs2, old_phys_rd;
    logic      free_list_empty;

    always #5 clk = ~clk;

    register_rename dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .rd              (rd),
        .rs1             (rs1),
        .rs2             (rs2),
        .issue_valid     (issue_valid),
        .retire_valid    (retire_valid),
        .retire_phys_reg (retire_phys_reg),
        .phys_rd         (phys_rd),
        .phys_rs1        (phys_rs1),
        .phys_rs2        (phys_rs2),
        .old_phys_rd     (old_phys_rd),
        .free_list_empty (free_list_empty)
    );

    typedef struct {
        int prd;
        int ps1;
        int ps2;
        int old;
        int emp;
        int id;
    } exp_t;

    exp_t sb[$];
    int   rat[32];
    int   fl[$];
    int   inflight[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   next_id    = 0;

    task automatic chk(input string nm, input int id, input int act, input int exp_v);
        compared++;
        if (act != exp_v) begin
            mismatched++;
            $display("FAIL %s txn %0d: got %0d, expected %0d", nm, id, act, exp_v);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) rat[i] = i;
        fl.delete();
        for (int i = 32; i < 64; i++) fl.push_back(i);
        inflight.delete();
    endfunction

    function automatic exp_t predict(input int d, input int s1, input int s2);
        exp_t e;
        e.emp = (fl.size() == 0) ? 1 : 0;
        e.ps1 = (s1 == 0) ? 0 : rat[s1];
        e.ps2 = (s2 == 0) ? 0 : rat[s2];
        e.old = (d == 0) ? 0 : rat[d];
        e.prd = (d == 0 || e.emp == 1) ? 0 : fl[0];
        e.id  = next_id;
        next_id++;
        return e;
    endfunction

    task automatic step(input int d, input int s1, input int s2,
                        input bit iv, input bit rv, input int rp);
        exp_t e;
        bit   alloc;
        bit   ret;
        @(negedge clk);
        reset_n         = 1'b1;
        rd              = arch_reg_t'(d);
        rs1             = arch_reg_t'(s1);
        rs2             = arch_reg_t'(s2);
        issue_valid     = iv;
        retire_valid    = rv;
        retire_phys_reg = phys_reg_t'(rp);
        e = predict(d, s1, s2);
        sb.push_back(e);
        alloc = iv && (d != 0) && (fl.size() != 0);
        ret   = rv && (rp != 0) && (fl.size() != 63);
        if (alloc) begin
            inflight.push_back(rat[d]);
            rat[d] = fl.pop_front();
        end
        if (ret) fl.push_back(rp);
    endtask

    task automatic reset_check(input int d, input int s1, input int s2);
        @(negedge clk);
        reset_n      = 1'b0;
        rd           = arch_reg_t'(d);
        rs1          = arch_reg_t'(s1);
        rs2          = arch_reg_t'(s2);
        issue_valid  = 1'b1;
        retire_valid = 1'b0;
        model_reset();
        sb.push_back(predict(d, s1, s2));
    endtask

    // Monitor: outputs are combinational, so compare a settled sample each low phase.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("phys_rd",         e.id, int'(phys_rd),         e.prd);
                chk("phys_rs1",        e.id, int'(phys_rs1),        e.ps1);
                chk("phys_rs2",        e.id, int'(phys_rs2),        e.ps2);
                chk("old_phys_rd",     e.id, int'(old_phys_rd),     e.old);
                chk("free_list_empty", e.id, int'(free_list_empty), e.emp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rp;
        bit rv;
        reset_n         = 1'b0;
        rd              = '0;
        rs1             = '0;
        rs2             = '0;
        issue_valid     = 1'b0;
        retire_valid    = 1'b0;
        retire_phys_reg = '0;
        model_reset();
        repeat (2) @(posedge clk);

        step(1, 0, 0, 0, 0, 0);            // reset state, no issue
        step(1, 2, 3, 1, 0, 0);            // phys_rd 32, old 1
        step(2, 4, 1, 1, 0, 0);            // phys_rd 33, rs2 -> 32
        step(3, 5, 2, 1, 0, 0);            // phys_rd 34, rs2 -> 33
        step(1, 1, 3, 1, 0, 0);            // rs1 == rd sees old mapping 32
        step(1, 1, 0, 0, 0, 0);            // RAT[1] now 35
        step(9, 1, 2, 1, 1, 1);            // alloc + retire of 1 together
        for (int k = 0; k < 40 && fl.size() > 0; k++)
            step($urandom_range(1, 31), $urandom_range(0, 31), $urandom_range(0, 31), 1, 0, 0);
        step(4, 1, 4, 1, 0, 0);            // empty: phys_rd 0, no RAT write
        step(4, 4, 1, 0, 1, 5);            // RAT[4] unchanged; retire 5
        step(8, 4, 8, 1, 0, 0);            // phys_rd 5
        step(0, 7, 3, 1, 0, 0);            // rd 0: no pop
        step(6, 8, 7, 0, 0, 0);
        reset_check(5, 7, 3);              // mid-stream reset takes effect at once

        for (int k = 0; k < 500; k++) begin
            rv = 1'b0;
            rp = 0;
            if (inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
                rv = 1'b1;
                rp = inflight.pop_front();
            end else if ($urandom_range(0, 15) == 0) begin
                rv = 1'b1;
            end
            step($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 3) != 0, rv, rp);
        end
        reset_check(12, 12, 0);
        step(12, 12, 31, 0, 0, 0);

        repeat (3) @(negedge clk);
        #5;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d pending, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
